maf_t3_2_stage: RTL and testbench
=================================

Name: maf_t3_2_stage

Overview:
- Second half of MAF pipeline stage 3. Consumes the stage-3 first-half products: four Wallace partial-product rows, the aligned/conditionally inverted addend, and per-lane carry-in/sticky bits.
- Performs lane-aware 5:2 compression, then the final carry-propagate add.
- Delivers the raw two's-complement sum, per-lane sign and carry-out, and the delayed control sideband to the normalize/round stage (T4).
- Two internal register stages, with a pipeline hold.

Parameters:
- DW, 74, datapath width (addend width; rows are zero-extended to DW).
- RW, 72, width of one Wallace row in the 288-bit input bus.
- LB, 37, lane boundary bit for dual-lane mode.

Ports:
- clk  in  1  clock
- rstn  in  1  async active-low reset
- hold  in  1  1 = freeze both internal stages
- valid_in  in  1  input beat valid
- cont  in  3  mode: 000 one wide lane, 001 two lanes split at LB, 010 single lane in bits [LB-1:0]
- level3_in  in  288  row i = level3_in[RW*i+RW-1:RW*i], i=0..3
- sh_rev_in  in  DW  aligned addend, already inverted for effective subtract
- sti_in  in  4  [0] lane0 carry-in; [1] lane1 carry-in; [3:2] sticky lane0/lane1
- sign_in  in  6  {S_C_H,S_B_H,S_A_H,S_C,S_B,S_A}
- trap_in_0, trap_in_1  in  4 each  trap codes per lane
- trap_ans_in_0, trap_ans_in_1  in  3 each  trap answers per lane
- d_in, e_in  in  12 each  alignment distance, exponent
- valid_out  out  1  result valid
- sum_out  out  DW  final sum
- cout_out  out  2  per-lane carry-out
- neg_out  out  2  per-lane sign (lane MSB of sum)
- sticky_out  out  2  delayed sti_in[3:2]
- cont_out, sign_out, trap_out_0/1, trap_ans_out_0/1, d_out, e_out  out  same widths as inputs  sideband delayed to match sum_out

Behaviour:
- Reset: rstn asynchronous, active-low; clock clk. While rstn=0, every register and output is 0, including valid_out.
- Latency: 2 cycles from valid_in to valid_out, counting only non-hold cycles. Throughput is 1 beat per cycle.
- Stage A (combinational, then register):
  - Compress the 4 rows plus sh_rev_in into sum/carry vectors, DW bits each.
  - Carry into bit LB is killed when cont=001.
  - Lane carry-ins are injected at bit 0 (sti[0]) and at bit LB (sti[1], cont=001 only).
  - Register S, C, and all sideband.
- Stage B (combinational, then register):
  - Compute S + (C<<1) + carry-ins, with the carry chain broken at LB in mode 001.
  - cont=000: cout_out[0] = carry out of bit DW-1; neg_out[0] = sum[DW-1]; cout_out[1] = neg_out[1] = 0.
  - cont=001: lane0 covers [LB-1:0], lane1 covers [DW-1:LB]; cout_out and neg_out are set per lane.
  - cont=010: only bits [LB-1:0] are valid; sum_out[DW-1:LB] = 0; lane0 flags are taken at bit LB-1; lane1 flags = 0.
  - cont=011..111 (reserved): processed as 000; cont_out still carries the original value.
- hold=1: both stages retain all contents; outputs are stable; valid_in is ignored (the upstream stage also stalls).
- Bubbles: valid=0 beats still propagate data registers. Downstream qualifies on valid_out.
- Traps: trap fields pass through unchanged. The datapath is not masked.
- Reset mid-operation: in-flight beats are discarded; valid_out = 0 on the first clock edge after release until new data arrives.
- Width rule: all additions are modulo 2^DW per lane; no saturation.

Decomposition:
- Shared package/include:
  - cont mode constants MODE_WIDE=3'b000, MODE_DUAL=3'b001, MODE_SINGLE=3'b010.
  - DW/RW/LB defaults.
  - Sideband bundle width constant (6+8+6+24+3 bits).
- One natural sub-module: maf_csa_5to2 (lane-aware 5:2 compressor with a kill_at_lb input), instantiated in Stage A.
- The final adder stays inline.

Test Plan:
- cont=000; rows 0x1, 0x2, 0x3, 0x4; sh_rev=0x10; sti=0, valid_in=1 -> 2 cycles later valid_out=1, sum_out=0x1A, cout=00, neg=00.
- cont=001; row0 = 2^37-1 (lane0 all ones), other rows 0; sh_rev=1; sti=0 -> sum_out lane0 = 0, cout_out[0]=1, lane1 = 0 (no carry across LB).
- cont=000; sh_rev = ~0x5 (effective subtract); row0 = 0x3; sti[0]=1 -> sum_out = 0x3-0x5 = all ones minus 1 (i.e. -2), neg_out[0]=1.
- Back-to-back beats A, B, C with hold=1 for 3 cycles after B enters -> outputs freeze during hold; A, B, C emerge in order with matching d_out/e_out/trap fields.
- cont=010; row0 = 0x1_0000_0000, sh_rev bits above LB set -> sum_out[73:37] = 0, lane1 flags = 0.
- Assert rstn=0 while 2 beats are in flight -> all outputs 0 immediately; valid_out stays 0 until a new valid_in completes 2 cycles after release.

Source files
------------

// File: rtl/maf_t3_2_stage_pkg.sv
// Shared constants and types for the MAF stage-3 second half: lane modes, widths, sideband bundle.
package maf_t3_2_stage_pkg;

    localparam int DW_DEF = 74;
    localparam int RW_DEF = 72;
    localparam int LB_DEF = 37;

    localparam logic [2:0] MODE_WIDE   = 3'b000;
    localparam logic [2:0] MODE_DUAL   = 3'b001;
    localparam logic [2:0] MODE_SINGLE = 3'b010;

    // cont + sign + traps + trap answers + d/e
    localparam int SB_W = 3 + 6 + 8 + 6 + 24;

    typedef enum logic [1:0] {
        LANE_WIDE,
        LANE_DUAL,
        LANE_SINGLE
    } lane_mode_e;

    typedef struct packed {
        logic [2:0]  cont;
        logic [5:0]  sign;
        logic [3:0]  trap_0;
        logic [3:0]  trap_1;
        logic [2:0]  trap_ans_0;
        logic [2:0]  trap_ans_1;
        logic [11:0] d;
        logic [11:0] e;
    } sideband_t;

    // Reserved cont encodings fall back to the wide lane.
    function automatic lane_mode_e lane_mode(input logic [2:0] cont);
        case (cont)
            MODE_WIDE:   return LANE_WIDE;
            MODE_DUAL:   return LANE_DUAL;
            MODE_SINGLE: return LANE_SINGLE;
            default:     return LANE_WIDE;
        endcase
    endfunction

endpackage

// File: rtl/maf_t3_2_stage_if.sv
// Beat interface between the stage-3 first half, this block, and the normalize/round stage.
interface maf_t3_2_stage_if
    import maf_t3_2_stage_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int RW = RW_DEF
) ();

    logic            hold;
    logic            valid_in;
    logic [2:0]      cont_in;
    logic [4*RW-1:0] level3_in;
    logic [DW-1:0]   sh_rev_in;
    logic [3:0]      sti_in;
    logic [5:0]      sign_in;
    logic [3:0]      trap_in_0;
    logic [3:0]      trap_in_1;
    logic [2:0]      trap_ans_in_0;
    logic [2:0]      trap_ans_in_1;
    logic [11:0]     d_in;
    logic [11:0]     e_in;

    logic            valid_out;
    logic [DW-1:0]   sum_out;
    logic [1:0]      cout_out;
    logic [1:0]      neg_out;
    logic [1:0]      sticky_out;
    logic [2:0]      cont_out;
    logic [5:0]      sign_out;
    logic [3:0]      trap_out_0;
    logic [3:0]      trap_out_1;
    logic [2:0]      trap_ans_out_0;
    logic [2:0]      trap_ans_out_1;
    logic [11:0]     d_out;
    logic [11:0]     e_out;

    modport master (
        output hold, valid_in, cont_in, level3_in, sh_rev_in, sti_in, sign_in,
               trap_in_0, trap_in_1, trap_ans_in_0, trap_ans_in_1, d_in, e_in,
        input  valid_out, sum_out, cout_out, neg_out, sticky_out, cont_out, sign_out,
               trap_out_0, trap_out_1, trap_ans_out_0, trap_ans_out_1, d_out, e_out
    );

    modport slave (
        input  hold, valid_in, cont_in, level3_in, sh_rev_in, sti_in, sign_in,
               trap_in_0, trap_in_1, trap_ans_in_0, trap_ans_in_1, d_in, e_in,
        output valid_out, sum_out, cout_out, neg_out, sticky_out, cont_out, sign_out,
               trap_out_0, trap_out_1, trap_ans_out_0, trap_ans_out_1, d_out, e_out
    );

endinterface

// File: rtl/maf_t3_2_stage_csa.sv
// Lane-aware 5:2 compressor: s_out + c_out equals the lane-wise sum of the five inputs plus carry-ins.
// c_out is already weight-aligned (shifted), so the final adder needs no further shift.
module maf_csa_5to2 #(
    parameter int DW = 74,
    parameter int LB = 37
) (
    input  logic [DW-1:0] in0,
    input  logic [DW-1:0] in1,
    input  logic [DW-1:0] in2,
    input  logic [DW-1:0] in3,
    input  logic [DW-1:0] in4,
    input  logic          kill_at_lb,
    input  logic          cin0,
    input  logic          cin_lb,
    output logic [DW-1:0] s_out,
    output logic [DW-1:0] c_out
);

    function automatic logic [DW-2:0] maj(input logic [DW-2:0] a, input logic [DW-2:0] b,
                                          input logic [DW-2:0] c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    logic [DW-1:0] s1, s2, c1s, c2s;
    logic [DW-2:0] c1, c2;

    always_comb begin
        s1  = in0 ^ in1 ^ in2;
        c1  = maj(in0[DW-2:0], in1[DW-2:0], in2[DW-2:0]);
        s2  = s1 ^ in3 ^ in4;
        c2  = maj(s1[DW-2:0], in3[DW-2:0], in4[DW-2:0]);
        // The vacated LSB slots of the shifted carries carry the lane carry-ins.
        c1s = {c1, cin0};
        c2s = {c2, 1'b0};
        if (kill_at_lb) begin
            c1s[LB] = 1'b0;
            c2s[LB] = cin_lb;
        end
        s_out = s2 ^ c1s ^ c2s;
        c_out = {maj(s2[DW-2:0], c1s[DW-2:0], c2s[DW-2:0]), 1'b0};
        if (kill_at_lb) c_out[LB] = 1'b0;
    end

endmodule

// File: rtl/maf_t3_2_stage.sv
// MAF stage 3 second half: 5:2 compression into a register, then the lane-split carry-propagate add.
// Both pipeline registers freeze together on hold.
module maf_t3_2_stage
    import maf_t3_2_stage_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int RW = RW_DEF,
    parameter int LB = LB_DEF
) (
    input logic             clk,
    input logic             rstn,
    maf_t3_2_stage_if.slave bus
);

    logic [DW-1:0] row [4];
    logic [DW-1:0] s_w, c_w;
    lane_mode_e    mode_in, mode_b;
    logic          dual_in;
    sideband_t     sb_in, sb_a, sb_b;

    for (genvar i = 0; i < 4; i++) begin : g_row
        assign row[i] = {{(DW-RW){1'b0}}, bus.level3_in[RW*i +: RW]};
    end

    assign mode_in = lane_mode(bus.cont_in);
    assign dual_in = (mode_in == LANE_DUAL);

    always_comb begin
        sb_in            = '0;
        sb_in.cont       = bus.cont_in;
        sb_in.sign       = bus.sign_in;
        sb_in.trap_0     = bus.trap_in_0;
        sb_in.trap_1     = bus.trap_in_1;
        sb_in.trap_ans_0 = bus.trap_ans_in_0;
        sb_in.trap_ans_1 = bus.trap_ans_in_1;
        sb_in.d          = bus.d_in;
        sb_in.e          = bus.e_in;
    end

    maf_csa_5to2 #(.DW(DW), .LB(LB)) u_csa (
        .in0        (row[0]),
        .in1        (row[1]),
        .in2        (row[2]),
        .in3        (row[3]),
        .in4        (bus.sh_rev_in),
        .kill_at_lb (dual_in),
        .cin0       (bus.sti_in[0]),
        .cin_lb     (bus.sti_in[1] & dual_in),
        .s_out      (s_w),
        .c_out      (c_w)
    );

    logic            valid_a_q;
    logic [DW-1:0]   s_a_q, c_a_q;
    logic [1:0]      sticky_a_q;
    logic [SB_W-1:0] sb_a_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            valid_a_q  <= 1'b0;
            s_a_q      <= '0;
            c_a_q      <= '0;
            sticky_a_q <= '0;
            sb_a_q     <= '0;
        end else if (!bus.hold) begin
            valid_a_q  <= bus.valid_in;
            s_a_q      <= s_w;
            c_a_q      <= c_w;
            sticky_a_q <= bus.sti_in[3:2];
            sb_a_q     <= sb_in;
        end
    end

    assign sb_a   = sb_a_q;
    assign mode_b = lane_mode(sb_a.cont);

    logic [LB:0]    lo;
    logic [DW-LB:0] hi;
    logic [DW:0]    full;
    logic [DW-1:0]  sum_d;
    logic [1:0]     cout_d, neg_d;

    // In dual mode c_a_q[LB] is already zero, so the lo/hi halves are independent lanes.
    always_comb begin
        lo     = {1'b0, s_a_q[LB-1:0]} + {1'b0, c_a_q[LB-1:0]};
        hi     = {1'b0, s_a_q[DW-1:LB]} + {1'b0, c_a_q[DW-1:LB]};
        full   = {1'b0, s_a_q} + {1'b0, c_a_q};
        sum_d  = full[DW-1:0];
        cout_d = {1'b0, full[DW]};
        neg_d  = {1'b0, full[DW-1]};
        case (mode_b)
            LANE_DUAL: begin
                sum_d  = {hi[DW-LB-1:0], lo[LB-1:0]};
                cout_d = {hi[DW-LB], lo[LB]};
                neg_d  = {hi[DW-LB-1], lo[LB-1]};
            end
            LANE_SINGLE: begin
                sum_d  = {{(DW-LB){1'b0}}, lo[LB-1:0]};
                cout_d = {1'b0, lo[LB]};
                neg_d  = {1'b0, lo[LB-1]};
            end
            default: ;
        endcase
    end

    logic            valid_b_q;
    logic [DW-1:0]   sum_b_q;
    logic [1:0]      cout_b_q, neg_b_q, sticky_b_q;
    logic [SB_W-1:0] sb_b_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            valid_b_q  <= 1'b0;
            sum_b_q    <= '0;
            cout_b_q   <= '0;
            neg_b_q    <= '0;
            sticky_b_q <= '0;
            sb_b_q     <= '0;
        end else if (!bus.hold) begin
            valid_b_q  <= valid_a_q;
            sum_b_q    <= sum_d;
            cout_b_q   <= cout_d;
            neg_b_q    <= neg_d;
            sticky_b_q <= sticky_a_q;
            sb_b_q     <= sb_a_q;
        end
    end

    assign sb_b               = sb_b_q;
    assign bus.valid_out      = valid_b_q;
    assign bus.sum_out        = sum_b_q;
    assign bus.cout_out       = cout_b_q;
    assign bus.neg_out        = neg_b_q;
    assign bus.sticky_out     = sticky_b_q;
    assign bus.cont_out       = sb_b.cont;
    assign bus.sign_out       = sb_b.sign;
    assign bus.trap_out_0     = sb_b.trap_0;
    assign bus.trap_out_1     = sb_b.trap_1;
    assign bus.trap_ans_out_0 = sb_b.trap_ans_0;
    assign bus.trap_ans_out_1 = sb_b.trap_ans_1;
    assign bus.d_out          = sb_b.d;
    assign bus.e_out          = sb_b.e;

endmodule

// File: tb/tb_maf_t3_2_stage.sv
// Directed bench for maf_t3_2_stage: lane modes, carry-ins, hold, bubbles and mid-flight reset.
module tb_maf_t3_2_stage;
    import maf_t3_2_stage_pkg::*;

    logic clk = 1'b0;
    logic rstn;
    int   checks = 0;
    int   errors = 0;

    maf_t3_2_stage_if bus ();

    maf_t3_2_stage dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", nm, obs, exp);
        end
    endtask

    task automatic drive(input logic [2:0] c, input logic [71:0] r0, input logic [71:0] r1,
                         input logic [71:0] r2, input logic [71:0] r3, input logic [73:0] sh,
                         input logic [3:0] st, input logic [11:0] tag);
        bus.valid_in      = 1'b1;
        bus.cont_in       = c;
        bus.level3_in     = {r3, r2, r1, r0};
        bus.sh_rev_in     = sh;
        bus.sti_in        = st;
        bus.sign_in       = tag[5:0];
        bus.trap_in_0     = tag[3:0];
        bus.trap_in_1     = ~tag[3:0];
        bus.trap_ans_in_0 = tag[2:0];
        bus.trap_ans_in_1 = tag[5:3];
        bus.d_in          = tag;
        bus.e_in          = ~tag;
    endtask

    task automatic bubble();
        bus.valid_in = 1'b0;
    endtask

    task automatic chk_out(input string nm, input logic [73:0] es, input logic [1:0] ec,
                           input logic [1:0] en, input logic [2:0] c, input logic [1:0] stk,
                           input logic [11:0] tag);
        logic [3:0]  t1;
        logic [11:0] einv;
        t1   = ~tag[3:0];
        einv = ~tag;
        chk({nm, ".valid"},  bus.valid_out,      1'b1);
        chk({nm, ".sum"},    bus.sum_out,        es);
        chk({nm, ".cout"},   bus.cout_out,       ec);
        chk({nm, ".neg"},    bus.neg_out,        en);
        chk({nm, ".sticky"}, bus.sticky_out,     stk);
        chk({nm, ".cont"},   bus.cont_out,       c);
        chk({nm, ".sign"},   bus.sign_out,       tag[5:0]);
        chk({nm, ".trap0"},  bus.trap_out_0,     tag[3:0]);
        chk({nm, ".trap1"},  bus.trap_out_1,     t1);
        chk({nm, ".ans0"},   bus.trap_ans_out_0, tag[2:0]);
        chk({nm, ".ans1"},   bus.trap_ans_out_1, tag[5:3]);
        chk({nm, ".d"},      bus.d_out,          tag);
        chk({nm, ".e"},      bus.e_out,          einv);
    endtask

    // One isolated beat: present, capture, then a bubble behind it.
    task automatic issue(input logic [2:0] c, input logic [71:0] r0, input logic [71:0] r1,
                         input logic [73:0] sh, input logic [3:0] st, input logic [11:0] tag);
        drive(c, r0, r1, 72'h0, 72'h0, sh, st, tag);
        tick();
        bubble();
        tick();
    endtask

    initial begin
        rstn = 1'b0;
        bus.hold = 1'b0;
        drive(MODE_WIDE, 72'h0, 72'h0, 72'h0, 72'h0, 74'h0, 4'h0, 12'h0);
        bubble();
        #2;
        chk("rst.valid", bus.valid_out, 1'b0);
        chk("rst.sum",   bus.sum_out,   74'h0);
        chk("rst.cout",  bus.cout_out,  2'b00);
        chk("rst.d",     bus.d_out,     12'h0);
        tick();
        tick();
        rstn = 1'b1;

        drive(MODE_WIDE, 72'h1, 72'h2, 72'h3, 72'h4, 74'h10, 4'h0, 12'h0A1);
        tick();
        bubble();
        chk("v1.latency", bus.valid_out, 1'b0);
        tick();
        chk_out("v1", 74'h1A, 2'b00, 2'b00, MODE_WIDE, 2'b00, 12'h0A1);
        tick();
        chk("v1.bubble", bus.valid_out, 1'b0);

        issue(MODE_DUAL, 72'h1F_FFFF_FFFF, 72'h0, 74'h1, 4'h0, 12'h0B2);
        chk_out("v2", 74'h0, 2'b01, 2'b00, MODE_DUAL, 2'b00, 12'h0B2);

        issue(MODE_WIDE, 72'h3, 72'h0, ~74'h5, 4'b0001, 12'h0C3);
        chk_out("v3", ~74'h1, 2'b00, 2'b01, MODE_WIDE, 2'b00, 12'h0C3);

        issue(MODE_DUAL, 72'h0, 72'h0, {37'h1F_FFFF_FFFF, 37'h0}, 4'b1110, 12'h0D4);
        chk_out("v4", 74'h0, 2'b10, 2'b00, MODE_DUAL, 2'b11, 12'h0D4);

        issue(MODE_SINGLE, 72'h1_0000_0000, 72'h0, {37'h1F_FFFF_FFFF, 37'h0}, 4'b0100, 12'h0E5);
        chk_out("v5", 74'h1_0000_0000, 2'b00, 2'b00, MODE_SINGLE, 2'b01, 12'h0E5);

        issue(MODE_SINGLE, 72'h1F_FFFF_FFFF, 72'h1, 74'h0, 4'h0, 12'h0F6);
        chk_out("v6", 74'h0, 2'b01, 2'b00, MODE_SINGLE, 2'b00, 12'h0F6);

        issue(MODE_SINGLE, 72'h10_0000_0000, 72'h0, {37'h1F_FFFF_FFFF, 37'h0}, 4'h0, 12'h107);
        chk_out("v6b", 74'h10_0000_0000, 2'b00, 2'b01, MODE_SINGLE, 2'b00, 12'h107);

        issue(3'b101, 72'h1F_FFFF_FFFF, 72'h0, 74'h1, 4'h0, 12'h218);
        chk_out("v7", 74'h20_0000_0000, 2'b00, 2'b00, 3'b101, 2'b00, 12'h218);

        issue(MODE_WIDE, 72'h1, 72'h0, {74{1'b1}}, 4'h0, 12'h329);
        chk_out("v8", 74'h0, 2'b01, 2'b00, MODE_WIDE, 2'b00, 12'h329);

        issue(MODE_DUAL, 72'h10_0000_0000, 72'h0, {37'h10_0000_0000, 37'h0}, 4'h0, 12'h43A);
        chk_out("v9", (74'h1 << 73) | (74'h1 << 36), 2'b00, 2'b11, MODE_DUAL, 2'b00, 12'h43A);

        drive(MODE_WIDE, 72'h11, 72'h0, 72'h0, 72'h0, 74'h22, 4'h0, 12'h111);
        tick();
        drive(MODE_WIDE, 72'h0, 72'h100, 72'h5, 72'h0, 74'h0, 4'h0, 12'h222);
        tick();
        chk_out("hA", 74'h33, 2'b00, 2'b00, MODE_WIDE, 2'b00, 12'h111);
        bus.hold = 1'b1;
        drive(MODE_DUAL, 72'h7, 72'h0, 72'h0, 72'h0, {37'h3, 37'h0}, 4'b1000, 12'h333);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_out("hold", 74'h33, 2'b00, 2'b00, MODE_WIDE, 2'b00, 12'h111);
        end
        bus.hold = 1'b0;
        tick();
        chk_out("hB", 74'h105, 2'b00, 2'b00, MODE_WIDE, 2'b00, 12'h222);
        bubble();
        tick();
        chk_out("hC", {37'h3, 37'h7}, 2'b00, 2'b00, MODE_DUAL, 2'b10, 12'h333);
        tick();
        chk("h.drain", bus.valid_out, 1'b0);

        drive(MODE_WIDE, 72'h5, 72'h0, 72'h0, 72'h0, 74'h0, 4'h0, 12'h444);
        tick();
        drive(MODE_WIDE, 72'h6, 72'h0, 72'h0, 72'h0, 74'h0, 4'h0, 12'h555);
        tick();
        chk("r.inflight", bus.valid_out, 1'b1);
        #2;
        rstn = 1'b0;
        #1;
        chk("r.valid", bus.valid_out,  1'b0);
        chk("r.sum",   bus.sum_out,    74'h0);
        chk("r.d",     bus.d_out,      12'h0);
        chk("r.trap1", bus.trap_out_1, 4'h0);
        bubble();
        tick();
        rstn = 1'b1;
        tick();
        chk("r.post1", bus.valid_out, 1'b0);
        tick();
        chk("r.post2", bus.valid_out, 1'b0);
        drive(MODE_WIDE, 72'h9, 72'h0, 72'h0, 72'h0, 74'h0, 4'h0, 12'h666);
        tick();
        bubble();
        chk("r.newlat", bus.valid_out, 1'b0);
        tick();
        chk_out("rF", 74'h9, 2'b00, 2'b00, MODE_WIDE, 2'b00, 12'h666);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
